// File: rtl/dft_pkg.sv
// ---------------------------------------------------------------------------
// dft_pkg
// Shared definitions for the DFT bin sequencer slice.
//   DFT_WIDTH : default component width (two's complement)
//   DFT_FRAC  : default number of fractional bits
//   state_t   : sequencer FSM states
// ---------------------------------------------------------------------------
package dft_pkg;

  localparam int DFT_WIDTH = 24;
  localparam int DFT_FRAC  = 8;

  // IDLE waits for start, CALC waits for the calculator, HOLD presents a bin
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/dft_power.sv
// ---------------------------------------------------------------------------
// dft_power
// Combinational squared magnitude of one complex bin, rescaled by FRAC.
// Ports:
//   i_re  : signed real part, WIDTH bits
//   i_im  : signed imaginary part, WIDTH bits
//   o_pow : (re*re + im*im) >> FRAC, unsigned, 2*WIDTH bits
// ---------------------------------------------------------------------------
module dft_power #(
  parameter int WIDTH = dft_pkg::DFT_WIDTH,
  parameter int FRAC  = dft_pkg::DFT_FRAC
) (
  input  logic signed [WIDTH-1:0]   i_re,
  input  logic signed [WIDTH-1:0]   i_im,
  output logic        [2*WIDTH-1:0] o_pow
);

  logic signed [2*WIDTH-1:0] w_reExt;
  logic signed [2*WIDTH-1:0] w_imExt;
  logic signed [2*WIDTH-1:0] w_reSq;
  logic signed [2*WIDTH-1:0] w_imSq;
  logic        [2*WIDTH:0]   w_sum;

  // Extend before multiplying so the full product fits; a square is never
  // negative, so each product can be added as an unsigned value.
  assign w_reExt = {{WIDTH{i_re[WIDTH-1]}}, i_re};
  assign w_imExt = {{WIDTH{i_im[WIDTH-1]}}, i_im};
  assign w_reSq  = w_reExt * w_reExt;
  assign w_imSq  = w_imExt * w_imExt;

  // One extra bit keeps the sum of two maximal squares from overflowing.
  assign w_sum   = {1'b0, w_reSq} + {1'b0, w_imSq};
  assign o_pow   = (2*WIDTH)'(w_sum >> FRAC);

endmodule

// File: rtl/dft_bin_sequencer.sv
// ---------------------------------------------------------------------------
// dft_bin_sequencer
// Walks an external component calculator through every DFT bin, captures each
// result together with its squared magnitude and hands it to a consumer over a
// valid/ready handshake.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   start                  : begin a full sweep (ignored while busy)
//   busy, done             : sweep in progress, one-cycle end-of-sweep pulse
//   comp_reset, comp_idx   : calculator control (held in reset between bins)
//   comp_ready/real/imag   : calculator result
//   out_valid, out_ready   : output handshake
//   out_idx/real/imag/pow  : captured bin and its squared magnitude
//   out_last               : marks bin SAMPLES-1
// ---------------------------------------------------------------------------
module dft_bin_sequencer
  import dft_pkg::*;
#(
  parameter int WIDTH   = DFT_WIDTH,
  parameter int FRAC    = DFT_FRAC,
  parameter int SAMPLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       comp_reset,
  output logic [$clog2(SAMPLES)-1:0] comp_idx,
  input  logic                       comp_ready,
  input  logic signed [WIDTH-1:0]    comp_real,
  input  logic signed [WIDTH-1:0]    comp_imag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(SAMPLES)-1:0] out_idx,
  output logic [WIDTH-1:0]           out_real,
  output logic [WIDTH-1:0]           out_imag,
  output logic [2*WIDTH-1:0]         out_pow,
  output logic                       out_last
);

  localparam int                IDXW     = $clog2(SAMPLES);
  localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(SAMPLES - 1);

  state_t               r_state;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_compReset;
  logic [IDXW-1:0]      r_compIdx;
  logic                 r_outValid;
  logic                 r_outLast;
  logic [IDXW-1:0]      r_outIdx;
  logic [WIDTH-1:0]     r_outReal;
  logic [WIDTH-1:0]     r_outImag;
  logic [2*WIDTH-1:0]   r_outPow;
  logic [2*WIDTH-1:0]   w_pow;

  dft_power #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_power (
    .i_re  (comp_real),
    .i_im  (comp_imag),
    .o_pow (w_pow)
  );

  // Sequencer FSM. All outputs are registered here; the calculator stays in
  // reset everywhere except CALC, so it restarts cleanly for every bin. The
  // magnitude is captured on the same edge as the raw components.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_compReset <= 1'b1;
      r_compIdx   <= '0;
      r_outValid  <= 1'b0;
      r_outLast   <= 1'b0;
      r_outIdx    <= '0;
      r_outReal   <= '0;
      r_outImag   <= '0;
      r_outPow    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= CALC;
            r_busy      <= 1'b1;
            r_compReset <= 1'b0;
            r_compIdx   <= '0;
          end
        end
        CALC: begin
          if (comp_ready) begin
            r_outReal   <= comp_real;
            r_outImag   <= comp_imag;
            r_outIdx    <= r_compIdx;
            r_outPow    <= w_pow;
            r_outValid  <= 1'b1;
            r_outLast   <= (r_compIdx == LAST_IDX);
            r_compReset <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            if (r_outLast) begin
              r_state   <= IDLE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_compIdx <= '0;
            end else begin
              r_compIdx   <= r_compIdx + 1'b1;
              r_compReset <= 1'b0;
              r_state     <= CALC;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_compReset <= 1'b1;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign comp_reset = r_compReset;
  assign comp_idx   = r_compIdx;
  assign out_valid  = r_outValid;
  assign out_last   = r_outLast;
  assign out_idx    = r_outIdx;
  assign out_real   = r_outReal;
  assign out_imag   = r_outImag;
  assign out_pow    = r_outPow;

endmodule

// File: tb/tb_dft_bin_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dft_bin_sequencer
// Pairs the sequencer with a behavioural 4-point component calculator and a
// back-pressuring consumer. Expected bins are queued whenever the calculator
// presents a result and are compared when the consumer accepts a bin.
// ---------------------------------------------------------------------------
module tb_dft_bin_sequencer;

  localparam int WIDTH   = 24;
  localparam int FRAC    = 8;
  localparam int SAMPLES = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic              comp_reset;
  logic [1:0]        comp_idx;
  logic              comp_ready = 1'b0;
  logic [WIDTH-1:0]  comp_real = '0;
  logic [WIDTH-1:0]  comp_imag = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [1:0]        out_idx;
  logic [WIDTH-1:0]  out_real;
  logic [WIDTH-1:0]  out_imag;
  logic [2*WIDTH-1:0] out_pow;
  logic              out_last;

  dft_bin_sequencer #(
    .WIDTH   (WIDTH),
    .FRAC    (FRAC),
    .SAMPLES (SAMPLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .comp_reset (comp_reset),
    .comp_idx   (comp_idx),
    .comp_ready (comp_ready),
    .comp_real  (comp_real),
    .comp_imag  (comp_imag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_real   (out_real),
    .out_imag   (out_imag),
    .out_pow    (out_pow),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  typedef struct {
    logic [1:0]         idx;
    logic [WIDTH-1:0]   re;
    logic [WIDTH-1:0]   im;
    logic [2*WIDTH-1:0] pow;
    logic               last;
  } binExp_t;

  binExp_t sbQueue[$];

  logic [WIDTH-1:0]   calcRe  [SAMPLES];
  logic [WIDTH-1:0]   calcIm  [SAMPLES];
  logic [2*WIDTH-1:0] calcPow [SAMPLES];

  // Independent reference for the squared magnitude.
  function automatic logic [2*WIDTH-1:0] powModel(input logic [WIDTH-1:0] re,
                                                  input logic [WIDTH-1:0] im);
    longint r;
    longint i;
    longint s;
    r = longint'($signed(re));
    i = longint'($signed(im));
    s = (r * r + i * i) >>> FRAC;
    return s[2*WIDTH-1:0];
  endfunction

  // Results of the 4-point calculator for input {2.0, 1.0, 2.0, 0.0} in Q.8.
  task automatic loadReferenceTable();
    calcRe[0] = 24'h000500; calcIm[0] = 24'h000000; calcPow[0] = 48'h1900;
    calcRe[1] = 24'h000002; calcIm[1] = 24'hffff01; calcPow[1] = 48'h00fe;
    calcRe[2] = 24'h000301; calcIm[2] = 24'h000000; calcPow[2] = 48'h0906;
    calcRe[3] = 24'h000002; calcIm[3] = 24'h000100; calcPow[3] = 48'h0100;
  endtask

  // Behavioural calculator: after calcLatency cycles out of reset it presents
  // the result for the requested bin until the sequencer resets it again.
  int calcLatency = 0;
  int calcCnt = 0;
  always @(posedge clk) begin
    #1;
    if (comp_reset) begin
      calcCnt    = 0;
      comp_ready = 1'b0;
    end else if (calcCnt >= calcLatency) begin
      comp_ready = 1'b1;
      comp_real  = calcRe[comp_idx];
      comp_imag  = calcIm[comp_idx];
    end else begin
      calcCnt++;
      comp_ready = 1'b0;
    end
  end

  // Consumer: with bpCycles > 0 each bin is refused for that many cycles.
  int bpCycles = 0;
  int holdCnt = 0;
  always @(posedge clk) begin
    #1;
    if (bpCycles == 0) begin
      out_ready = 1'b1;
    end else if (!out_valid) begin
      holdCnt   = 0;
      out_ready = 1'b0;
    end else if (holdCnt < bpCycles) begin
      holdCnt++;
      out_ready = 1'b0;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor at the falling edge, where DUT outputs and bench inputs are both
  // settled for the coming rising edge.
  logic               prevCap = 1'b0;
  logic               prevHold = 1'b0;
  logic [50:0]        heldFields = '0;
  logic [2*WIDTH-1:0] heldPow = '0;
  logic               expectDone = 1'b0;
  logic               checkLowRun = 1'b0;
  logic [1:0]         expCalcIdx = 2'd0;
  int                 lowRun = 0;
  int                 doneCount = 0;
  int                 binCount = 0;

  always @(negedge clk) begin
    binExp_t e;
    logic    accepted;
    logic    acceptedLast;

    if (prevCap) checkOutput("validLatency", out_valid, 1);
    prevCap = comp_ready && !comp_reset && !reset;

    if (prevCap) begin
      checkOutput("compIdx", comp_idx, expCalcIdx);
      e.idx  = expCalcIdx;
      e.re   = calcRe[expCalcIdx];
      e.im   = calcIm[expCalcIdx];
      e.pow  = calcPow[expCalcIdx];
      e.last = (expCalcIdx == 2'(SAMPLES - 1));
      sbQueue.push_back(e);
      expCalcIdx = expCalcIdx + 2'd1;
    end

    if (prevHold) begin
      checkOutput("holdStable", {out_idx, out_last, out_real, out_imag}, heldFields);
      checkOutput("holdPow", out_pow, heldPow);
      checkOutput("holdValid", out_valid, 1);
      checkOutput("holdCompReset", comp_reset, 1);
    end
    prevHold   = out_valid && !out_ready && !reset;
    heldFields = {out_idx, out_last, out_real, out_imag};
    heldPow    = out_pow;

    accepted     = out_valid && out_ready && !reset;
    acceptedLast = 1'b0;
    if (accepted) begin
      if (sbQueue.size() == 0) begin
        checkOutput("sbEmpty", 1, 0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("outIdx", out_idx, e.idx);
        checkOutput("outReal", out_real, e.re);
        checkOutput("outImag", out_imag, e.im);
        checkOutput("outPow", out_pow, e.pow);
        checkOutput("outLast", out_last, e.last);
        acceptedLast = e.last;
      end
      binCount++;
    end

    if (done || expectDone) checkOutput("donePulse", done, expectDone);
    if (done) doneCount++;
    expectDone = acceptedLast;

    if (!comp_reset) begin
      lowRun++;
    end else begin
      if (lowRun > 0 && checkLowRun) checkOutput("compResetLowRun", lowRun, 1);
      lowRun = 0;
    end
  end

  // Pulses start, waits (bounded) for the end-of-sweep pulse and checks that
  // exactly one full sweep of bins came out.
  task automatic applyStimulus(input int lat, input int bp, input int maxCycles);
    int baseDone;
    int baseBins;
    calcLatency = lat;
    bpCycles    = bp;
    baseDone    = doneCount;
    baseBins    = binCount;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("busyStart", busy, 1);
    for (int c = 0; c < maxCycles && doneCount == baseDone; c++) @(negedge clk);
    checkOutput("sweepDone", doneCount - baseDone, 1);
    checkOutput("sweepBins", binCount - baseBins, SAMPLES);
    @(negedge clk);
    checkOutput("busyEnd", busy, 0);
  endtask

  initial begin
    int baseDone;
    int baseBins;
    logic found;

    loadReferenceTable();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstCompReset", comp_reset, 1);
    checkOutput("rstCompIdx", comp_idx, 0);
    checkOutput("rstValid", out_valid, 0);
    checkOutput("rstLast", out_last, 0);
    checkOutput("rstOutIdx", out_idx, 0);
    checkOutput("rstReal", out_real, 0);
    checkOutput("rstImag", out_imag, 0);
    checkOutput("rstPow", out_pow, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] reference sweep, consumer always ready");
    applyStimulus(2, 0, 200);

    $display("[TB] back-pressure, 5 refused cycles per bin");
    applyStimulus(1, 5, 400);

    $display("[TB] zero-wait calculator");
    checkLowRun = 1'b1;
    applyStimulus(0, 0, 200);
    checkLowRun = 1'b0;

    $display("[TB] start pulsed while busy");
    calcLatency = 3;
    bpCycles    = 0;
    baseDone    = doneCount;
    baseBins    = binCount;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 200 && doneCount == baseDone; c++) @(negedge clk);
    repeat (20) @(negedge clk);
    checkOutput("ignoredStartDone", doneCount - baseDone, 1);
    checkOutput("ignoredStartBins", binCount - baseBins, SAMPLES);
    checkOutput("ignoredStartIdle", busy, 0);

    $display("[TB] reset during CALC of bin 2");
    calcLatency = 4;
    baseDone    = doneCount;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (comp_idx == 2'd2 && !comp_reset) found = 1'b1;
    end
    checkOutput("reachBin2Calc", found, 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortCompReset", comp_reset, 1);
    checkOutput("abortCompIdx", comp_idx, 0);
    checkOutput("abortValid", out_valid, 0);
    checkOutput("abortDone", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    sbQueue.delete();
    expCalcIdx = 2'd0;
    repeat (10) @(negedge clk);
    checkOutput("abortNoDone", doneCount - baseDone, 0);
    applyStimulus(1, 0, 200);

    $display("[TB] random components");
    for (int k = 0; k < SAMPLES; k++) begin
      calcRe[k]  = WIDTH'($urandom);
      calcIm[k]  = WIDTH'($urandom);
      calcPow[k] = powModel(calcRe[k], calcIm[k]);
    end
    applyStimulus(int'($urandom_range(0, 3)), 2, 300);

    checkOutput("sbDrained", sbQueue.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
